ex_div_stage: RTL and testbench
===============================

// Module: ex_div_stage
// PURPOSE
//  Execute stage directly downstream of instruction decode; consumes decoded aluop/alusel/operands/dest.
//  Computes logic, shift and move results combinationally; runs DIV/DIVU as a 32-iteration restoring divider.
//  Owns the HI/LO forwarding mux and raises a stall while dividing.
//  Drives its write-back fields into ex_mem and back to decode as the EX forwarding path.
// PARAMETERS
//  DIV_ITERS  32  divider iterations; one quotient bit per cycle. Only 32 is supported.
// PORTS
//  clk           in   1   stage clock
//  rst           in   1   reset: asynchronous, active-low (0 = reset)
//  aluop_i       in   8   decoded operation (`EXE_*_OP; DIV=8'b00011010, DIVU=8'b00011011)
//  alusel_i      in   3   result class (`EXE_RES_NOP/LOGIC/SHIFT/MOVE)
//  reg1_i        in   32  operand 1 (rs, or immediate)
//  reg2_i        in   32  operand 2 (rt, or immediate/shamt)
//  wd_i          in   5   destination register
//  wreg_i        in   1   destination write enable
//  annul_i       in   1   cancel any in-flight divide (pipeline flush)
//  hi_i, lo_i    in   32  architectural HI/LO
//  mem_whilo_i   in   1   MEM stage writes HI/LO; mem_hi_i/mem_lo_i in 32 carry the values
//  wb_whilo_i    in   1   WB stage writes HI/LO; wb_hi_i/wb_lo_i in 32 carry the values
//  wd_o          out  5   destination register (also the EX forward address to decode)
//  wreg_o        out  1   destination write enable (also the EX forward enable)
//  wdata_o       out  32  result (also the EX forward data)
//  whilo_o       out  1   write HI/LO this cycle; hi_o/lo_o out 32 carry the values
//  stallreq_o    out  1   hold IF/ID/EX inputs stable
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, counter=0, dividend/divisor regs=0. All outputs 0 while rst=0.
//  HI/LO view: MEM beats WB beats hi_i/lo_i.
//  Logic: OR/AND/XOR/NOR of reg1_i,reg2_i.
//  Shift: SLL/SRL/SRA shift reg2_i by reg1_i[4:0]; SRA sign-fills.
//  Move: MFHI/MFLO return the HI/LO view.
//  Move: MOVN/MOVZ return reg1_i; wreg_o forced 0 when the condition on reg2_i fails.
//  Move: MTHI/MTLO set whilo_o=1 and replace HI or LO with reg1_i; the other half keeps its view value.
//  wdata_o mux: select by alusel_i; NOP gives 0. wd_o=wd_i always.
//  FSM states: IDLE, DIV_ZERO, DIV_ON, DIV_END.
//  IDLE + aluop DIV/DIVU + !annul_i: latch operands; stallreq_o=1.
//  IDLE -> DIV_ZERO if reg2_i==0, else -> DIV_ON with counter=0.
//  DIVU latches raw operands. DIV latches absolute values and records both operand signs.
//  DIV_ZERO: one cycle; stallreq_o=1; result forced to 0; -> DIV_END.
//  DIV_ON: one restoring step per cycle (shift, trial subtract, set quotient bit); stallreq_o=1; after 32 steps -> DIV_END.
//  DIV_END: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; -> IDLE.
//  DIV_END sign fixup: quotient negated if operand signs differ; remainder takes the dividend's sign.
//  Latency: non-zero divide = 34 cycles from issue (1 IDLE + 32 DIV_ON + 1 DIV_END). Divide by zero = 3 cycles.
//  0x80000000 / -1 (DIV): lo=0x80000000, hi=0 (wraps, no trap).
//  Divide writes no GPR: wreg_o=0 on DIV/DIVU in every state.
//  annul_i=1 in any state: stallreq_o=0 and whilo_o=0 that cycle; FSM -> IDLE next edge; no result written.
//  Inputs are held stable by upstream while stallreq_o=1.
//  A new DIV is only accepted in IDLE, so back-to-back DIVs run serially.
//  rst asserted mid-divide: immediate return to IDLE, nothing written.
// TESTING
//  OR 0x0000FF00|0x00F000F0, wd=5, wreg=1 -> same cycle wdata_o=0x00F0FFF0, wd_o=5, wreg_o=1.
//  SRA reg2=0x80000010, reg1=4 -> wdata_o=0xF8000001. SRL -> 0x08000001.
//  MTHI 0x1234 with mem_whilo_i=1 (mem_hi=0xAAAA, mem_lo=0xBBBB) -> whilo_o=1, hi_o=0x1234, lo_o=0xBBBB.
//  MFLO: mem_whilo_i=1 and wb_whilo_i=1 both active -> returns mem_lo_i.
//  DIV -7/2 -> stallreq_o high 33 cycles; DIV_END: lo=0xFFFFFFFD, hi=0xFFFFFFFF, whilo_o=1 for exactly 1 cycle.
//  DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
//  DIV x/0 -> done in 3 cycles, hi=lo=0.
//  annul_i at cycle 10 of a divide -> stallreq_o=0, FSM IDLE next cycle, whilo_o never asserted.
//  rst=0 mid-divide -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_div_stage_if.sv
// Decode-to-execute bundle: decoded operation and operands in, write-back /
// EX-forwarding fields and the divide stall request out.
interface ex_div_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        annul_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo_i;
  logic [31:0] mem_hi_i;
  logic [31:0] mem_lo_i;
  logic        wb_whilo_i;
  logic [31:0] wb_hi_i;
  logic [31:0] wb_lo_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
           hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
           wb_whilo_i, wb_hi_i, wb_lo_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
           hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
           wb_whilo_i, wb_hi_i, wb_lo_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_stage.sv
// Execute stage: combinational logic/shift/move results, HI/LO forwarding
// view, and a one-bit-per-cycle restoring divider for DIV/DIVU that stalls
// the front of the pipeline while it runs.
module ex_div_stage #(
  parameter int DIV_ITERS = 32
) (
  input logic           clk,
  input logic           rst,
  ex_div_stage_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DIV_ITERS) + 1;

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_MOVZ = 8'b00001010;
  localparam logic [7:0] OP_MOVN = 8'b00001011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MTHI = 8'b00010001;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_MTLO = 8'b00010011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

  state_t state, state_nxt;

  logic                      is_div;
  logic                      is_signed_div;
  logic                      stall_div, latch_en, zero_en, step_en, div_done;
  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_W-1:0]         quo_q, rem_q, dvs_q;
  logic                      neg_quo_q, neg_rem_q;
  logic [DATA_W:0]           partial, trial;
  logic                      trial_ok;
  logic [DATA_W-1:0]         quo_fix, rem_fix;
  logic [DATA_W-1:0]         hi_view, lo_view;
  logic [DATA_W-1:0]         logic_res, shift_res, move_res;
  logic                      mov_ok;
  logic signed [DATA_W-1:0]  reg2_s;
  logic [4:0]                shamt;

  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  // Magnitude of a two's-complement value; 0x80000000 maps to itself, which
  // is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return u[DATA_W-1] ? neg_val(u) : u;
  endfunction

  assign is_div        = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
  assign is_signed_div = (bus.aluop_i == OP_DIV);
  assign reg2_s        = bus.reg2_i;
  assign shamt         = bus.reg1_i[4:0];

  // Divider state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Divider next-state: a flush always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (bus.annul_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (is_div) state_nxt = (bus.reg2_i == '0) ? DIV_ZERO : DIV_ON;
        DIV_ZERO: state_nxt = DIV_END;
        DIV_ON:   if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_nxt = DIV_END;
        DIV_END:  state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Divider control outputs; all suppressed by a flush.
  always_comb begin
    stall_div = 1'b0;
    latch_en  = 1'b0;
    zero_en   = 1'b0;
    step_en   = 1'b0;
    div_done  = 1'b0;
    if (!bus.annul_i) begin
      case (state)
        IDLE:     if (is_div) begin stall_div = 1'b1; latch_en = 1'b1; end
        DIV_ZERO: begin stall_div = 1'b1; zero_en = 1'b1; end
        DIV_ON:   begin stall_div = 1'b1; step_en = 1'b1; end
        DIV_END:  div_done = 1'b1;
        default:  ;
      endcase
    end
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the difference only when it does not borrow.
  always_comb begin
    partial  = {rem_q, quo_q[DATA_W-1]};
    trial    = partial - {1'b0, dvs_q};
    trial_ok = (partial >= {1'b0, dvs_q});
    quo_fix  = neg_quo_q ? neg_val(quo_q) : quo_q;
    rem_fix  = neg_rem_q ? neg_val(rem_q) : rem_q;
  end

  // Divider datapath: quo_q starts as the dividend magnitude and fills with
  // quotient bits from the bottom as the dividend bits shift out the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (latch_en) begin
      cnt_q <= '0;
      rem_q <= '0;
      if (is_signed_div) begin
        quo_q     <= abs_val(bus.reg1_i);
        dvs_q     <= abs_val(bus.reg2_i);
        neg_quo_q <= bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1];
        neg_rem_q <= bus.reg1_i[DATA_W-1];
      end else begin
        quo_q     <= bus.reg1_i;
        dvs_q     <= bus.reg2_i;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end
    end else if (zero_en) begin
      quo_q <= '0;
      rem_q <= '0;
    end else if (step_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= trial_ok ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], trial_ok};
    end
  end

  // Single-cycle results and the HI/LO view (MEM beats WB beats architectural).
  always_comb begin
    hi_view = bus.hi_i;
    lo_view = bus.lo_i;
    if (bus.mem_whilo_i) begin
      hi_view = bus.mem_hi_i;
      lo_view = bus.mem_lo_i;
    end else if (bus.wb_whilo_i) begin
      hi_view = bus.wb_hi_i;
      lo_view = bus.wb_lo_i;
    end

    logic_res = '0;
    case (bus.aluop_i)
      OP_OR:   logic_res = bus.reg1_i | bus.reg2_i;
      OP_AND:  logic_res = bus.reg1_i & bus.reg2_i;
      OP_XOR:  logic_res = bus.reg1_i ^ bus.reg2_i;
      OP_NOR:  logic_res = ~(bus.reg1_i | bus.reg2_i);
      default: logic_res = '0;
    endcase

    shift_res = '0;
    case (bus.aluop_i)
      OP_SLL:  shift_res = bus.reg2_i << shamt;
      OP_SRL:  shift_res = bus.reg2_i >> shamt;
      OP_SRA:  shift_res = reg2_s >>> shamt;
      default: shift_res = '0;
    endcase

    move_res = '0;
    mov_ok   = 1'b1;
    case (bus.aluop_i)
      OP_MFHI: move_res = hi_view;
      OP_MFLO: move_res = lo_view;
      OP_MOVN: begin move_res = bus.reg1_i; mov_ok = (bus.reg2_i != '0); end
      OP_MOVZ: begin move_res = bus.reg1_i; mov_ok = (bus.reg2_i == '0); end
      default: move_res = '0;
    endcase
  end

  // Output mux, forwarding fields and HI/LO write port; all 0 while in reset.
  always_comb begin
    bus.wd_o       = '0;
    bus.wreg_o     = 1'b0;
    bus.wdata_o    = '0;
    bus.whilo_o    = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    bus.stallreq_o = 1'b0;
    if (rst) begin
      bus.wd_o       = bus.wd_i;
      bus.wreg_o     = bus.wreg_i && !is_div && mov_ok;
      bus.stallreq_o = stall_div;
      case (bus.alusel_i)
        RES_LOGIC: bus.wdata_o = logic_res;
        RES_SHIFT: bus.wdata_o = shift_res;
        RES_MOVE:  bus.wdata_o = move_res;
        default:   bus.wdata_o = '0;
      endcase
      if (div_done) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = rem_fix;
        bus.lo_o    = quo_fix;
      end else if (!bus.annul_i && bus.aluop_i == OP_MTHI) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = bus.reg1_i;
        bus.lo_o    = lo_view;
      end else if (!bus.annul_i && bus.aluop_i == OP_MTLO) begin
        bus.whilo_o = 1'b1;
        bus.hi_o    = hi_view;
        bus.lo_o    = bus.reg1_i;
      end
    end
  end
endmodule

// File: tb/tb_ex_div_stage.sv
// Bench for ex_div_stage: directed cases plus randomized operations, with a
// queue of expected write-back fields consumed by an independent monitor.
module tb_ex_div_stage;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MOVZ = 8'h0A;
  localparam logic [7:0] OP_MOVN = 8'h0B;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] S_NOP   = 3'd0;
  localparam logic [2:0] S_LOGIC = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi, lo;
    logic        mw;
    logic [31:0] mh, ml;
    logic        ww;
    logic [31:0] wh, wl;
  } stim_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  bit    live = 1'b0;
  int    compared = 0;
  int    mismatched = 0;
  int    txn = 0;
  exp_t  sb[$];

  ex_div_stage_if bus ();

  ex_div_stage #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input logic [7:0] op, input logic [2:0] sel,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] wd, input logic wreg);
    stim_t s;
    s = '0;
    s.op = op; s.sel = sel; s.r1 = r1; s.r2 = r2; s.wd = wd; s.wreg = wreg;
    s.hi = 32'h0000_1111; s.lo = 32'h0000_2222;
    return s;
  endfunction

  function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                              input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo; e.hi = hi; e.lo = lo;
    return e;
  endfunction

  // Reference model: architectural meaning of each operation.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] vh, vl;
    logic signed [31:0] a, b;
    e  = mk(s.wd, s.wreg, 32'h0, 1'b0, 32'h0, 32'h0);
    vh = s.mw ? s.mh : (s.ww ? s.wh : s.hi);
    vl = s.mw ? s.ml : (s.ww ? s.wl : s.lo);
    a  = s.r1;
    b  = s.r2;
    case (s.op)
      OP_AND:  e.wdata = s.r1 & s.r2;
      OP_OR:   e.wdata = s.r1 | s.r2;
      OP_XOR:  e.wdata = s.r1 ^ s.r2;
      OP_NOR:  e.wdata = ~(s.r1 | s.r2);
      OP_SLL:  e.wdata = s.r2 << s.r1[4:0];
      OP_SRL:  e.wdata = s.r2 >> s.r1[4:0];
      OP_SRA:  e.wdata = b >>> s.r1[4:0];
      OP_MFHI: e.wdata = vh;
      OP_MFLO: e.wdata = vl;
      OP_MOVN: begin e.wdata = s.r1; e.wreg = s.wreg && (s.r2 != 0); end
      OP_MOVZ: begin e.wdata = s.r1; e.wreg = s.wreg && (s.r2 == 0); end
      OP_MTHI: begin e.whilo = 1'b1; e.hi = s.r1; e.lo = vl; end
      OP_MTLO: begin e.whilo = 1'b1; e.hi = vh; e.lo = s.r1; end
      OP_DIV: begin
        e.wreg = 1'b0; e.whilo = 1'b1;
        if (s.r2 == 0) begin e.hi = 0; e.lo = 0; end
        else if (s.r1 == 32'h8000_0000 && s.r2 == 32'hFFFF_FFFF) begin e.hi = 0; e.lo = 32'h8000_0000; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      OP_DIVU: begin
        e.wreg = 1'b0; e.whilo = 1'b1;
        if (s.r2 == 0) begin e.hi = 0; e.lo = 0; end
        else begin e.lo = s.r1 / s.r2; e.hi = s.r1 % s.r2; end
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int stall_of(input stim_t s);
    if (s.op == OP_DIV || s.op == OP_DIVU) return (s.r2 == 0) ? 2 : 33;
    return 0;
  endfunction

  task automatic apply(input stim_t s);
    bus.aluop_i = s.op;   bus.alusel_i = s.sel;
    bus.reg1_i = s.r1;    bus.reg2_i = s.r2;
    bus.wd_i = s.wd;      bus.wreg_i = s.wreg;
    bus.annul_i = 1'b0;
    bus.hi_i = s.hi;      bus.lo_i = s.lo;
    bus.mem_whilo_i = s.mw; bus.mem_hi_i = s.mh; bus.mem_lo_i = s.ml;
    bus.wb_whilo_i = s.ww;  bus.wb_hi_i = s.wh;  bus.wb_lo_i = s.wl;
  endtask

  // Present one instruction, hold it while the stage stalls, and check the
  // number of stalled cycles.
  task automatic issue(input stim_t s, input exp_t e, input int stall_exp, input string name);
    int  n;
    bit  done;
    @(posedge clk); #1;
    apply(s);
    live = 1'b1;
    sb.push_back(e);
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!bus.stallreq_o) done = 1'b1;
      else n++;
    end
    compared++;
    if (!done || n != stall_exp) begin
      mismatched++;
      $display("FAIL %s stall cycles: got %0d (done=%0b) expected %0d", name, n, done, stall_exp);
    end
  endtask

  task automatic check_zero(input string name);
    compared++;
    if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
      mismatched++;
      $display("FAIL %s: wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h stall=%0b, required all zero",
               name, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
    end
  endtask

  // Monitor: stalled cycles must not write HI/LO; every completing cycle
  // consumes one expected entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && live) begin
        if (bus.stallreq_o) begin
          compared++;
          if (bus.whilo_o !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_whilo: whilo_o=%0b while stalled, required 0", bus.whilo_o);
          end
        end else begin
          compared++;
          if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL txn%0d: output with no expected entry", txn);
          end else begin
            e = sb.pop_front();
            if (bus.wd_o !== e.wd || bus.wreg_o !== e.wreg || bus.wdata_o !== e.wdata ||
                bus.whilo_o !== e.whilo || bus.hi_o !== e.hi || bus.lo_o !== e.lo) begin
              mismatched++;
              $display("FAIL txn%0d: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h; expected wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h",
                       txn, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o,
                       e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo);
            end
          end
          txn++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    logic [31:0] r2;
    int k;

    // Reset: outputs held at zero regardless of inputs.
    apply(st(OP_OR, S_LOGIC, 32'hFFFF_0000, 32'h0000_FFFF, 5'd7, 1'b1));
    bus.aluop_i = OP_DIV;
    #12;
    check_zero("reset_outputs");
    apply(st(OP_NOP, S_NOP, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b1;

    // Directed single-cycle cases.
    issue(st(OP_OR, S_LOGIC, 32'h0000_FF00, 32'h00F0_00F0, 5'd5, 1'b1),
          mk(5'd5, 1'b1, 32'h00F0_FFF0, 1'b0, 0, 0), 0, "or");
    issue(st(OP_SRA, S_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1),
          mk(5'd7, 1'b1, 32'hF800_0001, 1'b0, 0, 0), 0, "sra");
    issue(st(OP_SRL, S_SHIFT, 32'd4, 32'h8000_0010, 5'd7, 1'b1),
          mk(5'd7, 1'b1, 32'h0800_0001, 1'b0, 0, 0), 0, "srl");
    s = st(OP_MTHI, S_NOP, 32'h1234, 0, 5'd0, 1'b0);
    s.mw = 1'b1; s.mh = 32'hAAAA; s.ml = 32'hBBBB;
    s.ww = 1'b1; s.wh = 32'hCCCC; s.wl = 32'hDDDD;
    issue(s, mk(5'd0, 1'b0, 0, 1'b1, 32'h1234, 32'hBBBB), 0, "mthi");
    s = st(OP_MFLO, S_MOVE, 0, 0, 5'd3, 1'b1);
    s.mw = 1'b1; s.ml = 32'hBBBB; s.ww = 1'b1; s.wl = 32'hCCCC;
    issue(s, mk(5'd3, 1'b1, 32'hBBBB, 1'b0, 0, 0), 0, "mflo_mem_over_wb");
    issue(st(OP_MOVZ, S_MOVE, 32'h55, 32'h1, 5'd4, 1'b1),
          mk(5'd4, 1'b0, 32'h55, 1'b0, 0, 0), 0, "movz_fail");
    issue(st(OP_MOVN, S_MOVE, 32'h66, 32'h3, 5'd4, 1'b1),
          mk(5'd4, 1'b1, 32'h66, 1'b0, 0, 0), 0, "movn_pass");

    // Directed divides.
    issue(st(OP_DIV, S_NOP, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b0),
          mk(5'd2, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD), 33, "div_m7_2");
    issue(st(OP_AND, S_LOGIC, 32'hF0F0, 32'hFF00, 5'd1, 1'b1),
          mk(5'd1, 1'b1, 32'hF000, 1'b0, 0, 0), 0, "and_after_div");
    issue(st(OP_DIVU, S_NOP, 32'hFFFF_FFFF, 32'h10, 5'd6, 1'b1),
          mk(5'd6, 1'b0, 0, 1'b1, 32'hF, 32'h0FFF_FFFF), 33, "divu_big");
    issue(st(OP_DIV, S_NOP, 32'd1234, 32'd0, 5'd6, 1'b0),
          mk(5'd6, 1'b0, 0, 1'b1, 0, 0), 2, "div_by_zero");
    issue(st(OP_DIV, S_NOP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0),
          mk(5'd6, 1'b0, 0, 1'b1, 0, 32'h8000_0000), 33, "div_min_m1");

    // Flush in the middle of a divide.
    @(posedge clk); #1;
    apply(st(OP_DIV, S_NOP, 32'd500, 32'd3, 5'd9, 1'b0));
    live = 1'b1;
    sb.push_back(mk(5'd9, 1'b0, 0, 1'b0, 0, 0));
    repeat (10) @(negedge clk);
    @(posedge clk); #1 bus.annul_i = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.stallreq_o !== 1'b0) begin
      mismatched++;
      $display("FAIL annul_stall: stallreq_o=%0b, required 0", bus.stallreq_o);
    end
    issue(st(OP_XOR, S_LOGIC, 32'hFF, 32'h0F, 5'd8, 1'b1),
          mk(5'd8, 1'b1, 32'hF0, 1'b0, 0, 0), 0, "after_annul");

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    live = 1'b0;
    apply(st(OP_DIV, S_NOP, 32'd1000, 32'd3, 5'd2, 1'b0));
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1 check_zero("rst_mid_div");
    apply(st(OP_NOP, S_NOP, 0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b1;
    issue(st(OP_DIV, S_NOP, 32'd100, 32'd7, 5'd3, 1'b0),
          mk(5'd3, 1'b0, 0, 1'b1, 32'd2, 32'd14), 33, "div_after_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 200; i++) begin
      s = st(OP_NOP, S_NOP, $urandom, $urandom, 5'($urandom), 1'($urandom));
      s.hi = $urandom; s.lo = $urandom;
      s.mw = 1'($urandom); s.mh = $urandom; s.ml = $urandom;
      s.ww = 1'($urandom); s.wh = $urandom; s.wl = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (i % 10 == 9) begin
        s.op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
        k = $urandom_range(0, 3);
        if (k == 0)      s.r2 = 0;
        else if (k == 1) s.r2 = $urandom_range(1, 300);
        else if (k == 2) s.r2 = -$urandom_range(1, 300);
        else             s.r2 = $urandom;
      end else begin
        case ($urandom_range(0, 12))
          0:  begin s.op = OP_AND;  s.sel = S_LOGIC; end
          1:  begin s.op = OP_OR;   s.sel = S_LOGIC; end
          2:  begin s.op = OP_XOR;  s.sel = S_LOGIC; end
          3:  begin s.op = OP_NOR;  s.sel = S_LOGIC; end
          4:  begin s.op = OP_SLL;  s.sel = S_SHIFT; end
          5:  begin s.op = OP_SRL;  s.sel = S_SHIFT; end
          6:  begin s.op = OP_SRA;  s.sel = S_SHIFT; end
          7:  begin s.op = OP_MFHI; s.sel = S_MOVE;  end
          8:  begin s.op = OP_MFLO; s.sel = S_MOVE;  end
          9:  begin s.op = OP_MOVN; s.sel = S_MOVE;  s.r2 = r2; end
          10: begin s.op = OP_MOVZ; s.sel = S_MOVE;  s.r2 = r2; end
          11: begin s.op = OP_MTHI; s.sel = S_NOP;   end
          default: begin s.op = OP_MTLO; s.sel = S_NOP; end
        endcase
      end
      issue(s, model(s), stall_of(s), "random");
    end

    @(posedge clk); #1;
    live = 1'b0;
    apply(st(OP_NOP, S_NOP, 0, 0, 0, 0));
    @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
